// File: rtl/uc_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg
// Shared definitions for the microc control unit:
//   - opcode class prefixes and full control opcodes
//   - ALU operation code used when no ALU operation is requested
//   - run-control state encoding
//   - decoded control bundle passed from uc_decoder to uc
// No ports (package).
// -----------------------------------------------------------------------------
package uc_pkg;

    // Opcode class prefixes (opcode[5:3])
    localparam logic [2:0] CLS_ALU_REG = 3'b000;
    localparam logic [2:0] CLS_ALU_IMM = 3'b001;
    localparam logic [2:0] CLS_CTRL    = 3'b010;

    // Control-flow opcodes (full 6-bit encodings)
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_NOP  = 6'b010011;
    localparam logic [5:0] OP_HALT = 6'b010100;

    // ALU operation codes: the ALU-class opcodes carry the operation in
    // opcode[2:0]; ALU_OP_NONE is driven whenever no ALU result is written.
    localparam logic [2:0] ALU_OP_NONE = 3'b000;
    localparam int         ALU_OP_W    = 3;

    // Run-control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TRAP = 2'd3
    } uc_state_e;

    // Raw decoded controls, before run-state gating
    typedef struct packed {
        logic                s_inc;
        logic                s_inm;
        logic                we;
        logic                wez;
        logic [ALU_OP_W-1:0] alu_op;
        logic                is_halt;
        logic                illegal;
    } uc_ctrl_t;

    // Fully inactive bundle: frozen PC on the jump target, no writes.
    localparam uc_ctrl_t CTRL_INACTIVE = '{
        s_inc:   1'b0,
        s_inm:   1'b0,
        we:      1'b0,
        wez:     1'b0,
        alu_op:  ALU_OP_NONE,
        is_halt: 1'b0,
        illegal: 1'b0
    };

    // Opcode class extraction
    function automatic logic [2:0] op_class(input logic [5:0] op);
        return op[5:3];
    endfunction

endpackage

// File: rtl/uc_decoder.sv
// -----------------------------------------------------------------------------
// uc_decoder
// Purely combinational opcode decoder for the microc control unit.
// Ports:
//   opcode  in  6   instruction opcode from the datapath
//   zero    in  1   registered zero flag from the datapath
//   ctrl    out     raw control bundle (s_inc, s_inm, we, wez, alu_op,
//                   is_halt, illegal); not gated by run state
// -----------------------------------------------------------------------------
module uc_decoder
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output uc_ctrl_t   ctrl
);

    uc_ctrl_t ctrl_s;

    // Decode opcode classes; anything not matched stays flagged illegal.
    always_comb begin
        ctrl_s         = CTRL_INACTIVE;
        ctrl_s.illegal = 1'b1;
        case (op_class(opcode))
            CLS_ALU_REG: begin
                ctrl_s.s_inc   = 1'b1;
                ctrl_s.s_inm   = 1'b0;
                ctrl_s.we      = 1'b1;
                ctrl_s.wez     = 1'b1;
                ctrl_s.alu_op  = opcode[2:0];
                ctrl_s.illegal = 1'b0;
            end
            CLS_ALU_IMM: begin
                ctrl_s.s_inc   = 1'b1;
                ctrl_s.s_inm   = 1'b1;
                ctrl_s.we      = 1'b1;
                ctrl_s.wez     = 1'b1;
                ctrl_s.alu_op  = opcode[2:0];
                ctrl_s.illegal = 1'b0;
            end
            CLS_CTRL: begin
                case (opcode)
                    OP_J: begin
                        ctrl_s.s_inc   = 1'b0;
                        ctrl_s.illegal = 1'b0;
                    end
                    OP_JZ: begin
                        // Take the branch (load target) when the flag is set.
                        ctrl_s.s_inc   = ~zero;
                        ctrl_s.illegal = 1'b0;
                    end
                    OP_JNZ: begin
                        ctrl_s.s_inc   = zero;
                        ctrl_s.illegal = 1'b0;
                    end
                    OP_NOP: begin
                        ctrl_s.s_inc   = 1'b1;
                        ctrl_s.illegal = 1'b0;
                    end
                    OP_HALT: begin
                        // Same datapath effect as J: the assembler points the
                        // target at this instruction, so the PC self-loops.
                        ctrl_s.s_inc   = 1'b0;
                        ctrl_s.is_halt = 1'b1;
                        ctrl_s.illegal = 1'b0;
                    end
                    default: begin
                        ctrl_s.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    assign ctrl = ctrl_s;

endmodule

// File: rtl/uc.sv
// -----------------------------------------------------------------------------
// uc
// Control unit for the microc single-cycle datapath. Decodes the opcode
// combinationally (zero decode latency) and gates the controls through a
// run-control state machine: IDLE -> RUN on start; RUN -> HALT on the HALT
// opcode; RUN -> TRAP on an illegal opcode. HALT and TRAP are left only by
// reset. Outside RUN, and on an illegal opcode, all controls are 0, which
// freezes the datapath on the current jump target.
//
// Optional feature macro: UC_PERF_EN
//   When defined, adds the `retired` port: a CNT_W-bit counter of legal
//   instructions executed in RUN (the HALT instruction included); wraps and
//   holds outside RUN.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   reset    in   1      asynchronous active-low reset
//   start    in   1      start pulse, IDLE -> RUN
//   opcode   in   6      instruction opcode
//   zero     in   1      datapath zero flag
//   s_inc    out  1      1 = PC+1, 0 = load jump target
//   s_inm    out  1      1 = immediate operand
//   we       out  1      register-file write enable
//   wez      out  1      zero-flag write enable
//   alu_op   out  3      ALU operation
//   running  out  1      state is RUN
//   halted   out  1      state is HALT
//   trap     out  1      state is TRAP
//   retired  out  CNT_W  retired-instruction count (UC_PERF_EN only)
// -----------------------------------------------------------------------------
module uc
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       alu_op,
    output logic             running,
    output logic             halted,
    output logic             trap
`ifdef UC_PERF_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    uc_state_e state_r;
    uc_ctrl_t  ctrl_s;
    logic      run_s;
    logic      exec_s;

    uc_decoder u_decoder (
        .opcode (opcode),
        .zero   (zero),
        .ctrl   (ctrl_s)
    );

    assign run_s  = (state_r == ST_RUN);
    // An instruction executes only in RUN and only if it decoded as legal.
    assign exec_s = run_s & ~ctrl_s.illegal;

    // Run-control state machine; HALT and TRAP are absorbing until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (ctrl_s.illegal) begin
                        state_r <= ST_TRAP;
                    end else if (ctrl_s.is_halt) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HALT: state_r <= ST_HALT;
                ST_TRAP: state_r <= ST_TRAP;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Gate the decoded controls; inactive means frozen PC and no writes.
    always_comb begin
        s_inc  = 1'b0;
        s_inm  = 1'b0;
        we     = 1'b0;
        wez    = 1'b0;
        alu_op = ALU_OP_NONE;
        if (exec_s) begin
            s_inc  = ctrl_s.s_inc;
            s_inm  = ctrl_s.s_inm;
            we     = ctrl_s.we;
            wez    = ctrl_s.wez;
            alu_op = ctrl_s.alu_op;
        end else begin
            s_inc  = 1'b0;
            s_inm  = 1'b0;
            we     = 1'b0;
            wez    = 1'b0;
            alu_op = ALU_OP_NONE;
        end
    end

    assign running = (state_r == ST_RUN);
    assign halted  = (state_r == ST_HALT);
    assign trap    = (state_r == ST_TRAP);

`ifdef UC_PERF_EN
    logic [CNT_W-1:0] retired_r;

    // Retired-instruction counter: +1 per executed instruction, natural wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_r <= '0;
        end else if (exec_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

endmodule
